// File: rtl/repeat_id_scanner_if.sv
// Range-offer channel between the puzzle-input loader and repeat_id_scanner.
// The loader drives the master side, and the scanner is the slave.
interface repeat_id_scanner_if #(
  parameter int DIGITS = 10
);
  logic                  range_valid;
  logic                  range_ready;
  logic [4*DIGITS-1:0]   range_lo;
  logic [4*DIGITS-1:0]   range_hi;
  logic                  range_last;
  logic                  mode;

  modport master (
    output range_valid,
    output range_lo,
    output range_hi,
    output range_last,
    output mode,
    input  range_ready
  );

  modport slave (
    input  range_valid,
    input  range_lo,
    input  range_hi,
    input  range_last,
    input  mode,
    output range_ready
  );
endinterface

// File: rtl/repeat_id_scanner.sv
// repeat_id_scanner: walks every ID in each offered packed-BCD range, one per
// cycle. It flags IDs that are made of a repeated digit pattern. In mode 0 the
// pattern must appear exactly twice; in mode 1 it must appear two or more times.
// It accumulates the binary sum and count of flagged IDs over a batch of ranges.
// The last range of a batch is marked by range_last.
module repeat_id_scanner #(
  parameter int DIGITS = 10,
  parameter int SUM_W  = 64,
  parameter int CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  repeat_id_scanner_if.slave   rng_if,
  output logic [SUM_W-1:0]     result,
  output logic [CNT_W-1:0]     id_count,
  output logic                 result_valid,
  output logic                 bad_range
);

  localparam int BW = 4 * DIGITS;
  localparam int LW = $clog2(DIGITS + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SCAN,
    ST_FLUSH,
    ST_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [BW-1:0]     r_lo;
  logic [BW-1:0]     r_hi;
  logic              r_last;
  logic              r_mode;
  logic [BW-1:0]     r_cur;

  logic              r_p1_flag;
  logic [BW-1:0]     r_p1_cur;

  logic [SUM_W-1:0]  r_sum;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_bad;

  logic              w_accept;
  logic              w_new_batch;
  logic              w_malformed;
  logic [LW-1:0]     w_len;
  logic              w_rep_two;
  logic              w_rep_any;
  logic              w_flag;
  logic [BW-1:0]     w_cur_inc;
  logic [SUM_W-1:0]  w_p1_bin;

  assign w_accept    = rng_if.range_valid && rng_if.range_ready;
  // Leaving DONE through an accept starts a fresh batch, so the old totals go.
  assign w_new_batch = w_accept && (r_state == ST_DONE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: CHECK vets the range once, and SCAN runs until hi has been evaluated.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept) begin
          w_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (w_malformed) begin
          w_next = r_last ? ST_FLUSH : ST_IDLE;
        end else begin
          w_next = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (r_cur == r_hi) begin
          w_next = r_last ? ST_FLUSH : ST_IDLE;
        end
      end
      ST_FLUSH: begin
        w_next = ST_DONE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Output logic: ready in IDLE/DONE (never while reset is held); totals valid in DONE.
  always_comb begin
    rng_if.range_ready = 1'b0;
    result_valid       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        rng_if.range_ready = ~rst;
      end
      ST_DONE: begin
        rng_if.range_ready = ~rst;
        result_valid       = 1'b1;
      end
      default: begin
        rng_if.range_ready = 1'b0;
        result_valid       = 1'b0;
      end
    endcase
  end

  // Range vetting: a non-decimal nibble in either bound, or lo above hi.
  // Bounds holding only valid BCD digits order the same way as the unsigned
  // packed vectors, so a plain unsigned compare is enough.
  always_comb begin
    w_malformed = (r_lo > r_hi);
    for (int i = 0; i < DIGITS; i++) begin
      if ((r_lo[4*i +: 4] > 4'd9) || (r_hi[4*i +: 4] > 4'd9)) begin
        w_malformed = 1'b1;
      end
    end
  end

  // Significant length of the candidate: position of its top nonzero digit + 1.
  always_comb begin
    w_len = LW'(1);
    for (int i = 1; i < DIGITS; i++) begin
      if (r_cur[4*i +: 4] != 4'd0) begin
        w_len = LW'(i + 1);
      end
    end
  end

  // Pattern match, unrolled for every possible length so that every digit index is constant.
  always_comb begin
    logic w_ok;
    w_rep_two = 1'b0;
    w_rep_any = 1'b0;
    w_ok      = 1'b0;
    for (int lc = 2; lc <= DIGITS; lc++) begin
      if (w_len == LW'(lc)) begin
        if ((lc % 2) == 0) begin
          w_ok = 1'b1;
          for (int i = 0; i < lc / 2; i++) begin
            if (r_cur[4*i +: 4] != r_cur[4*(i + lc/2) +: 4]) begin
              w_ok = 1'b0;
            end
          end
          w_rep_two = w_ok;
        end
        for (int p = 1; p < lc; p++) begin
          if ((lc % p) == 0) begin
            w_ok = 1'b1;
            for (int i = p; i < lc; i++) begin
              if (r_cur[4*i +: 4] != r_cur[4*(i - p) +: 4]) begin
                w_ok = 1'b0;
              end
            end
            if (w_ok) begin
              w_rep_any = 1'b1;
            end
          end
        end
      end
    end
  end

  assign w_flag = r_mode ? w_rep_any : w_rep_two;

  // Decimal increment of the candidate, which ripples a carry through the nines.
  always_comb begin
    logic w_carry;
    w_cur_inc = r_cur;
    w_carry   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_carry) begin
        if (r_cur[4*i +: 4] == 4'd9) begin
          w_cur_inc[4*i +: 4] = 4'd0;
        end else begin
          w_cur_inc[4*i +: 4] = r_cur[4*i +: 4] + 4'd1;
          w_carry             = 1'b0;
        end
      end
    end
  end

  // Stage-2 BCD to binary conversion by Horner: acc = acc*10 + digit, most significant digit first.
  always_comb begin
    w_p1_bin = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_p1_bin = (w_p1_bin << 3) + (w_p1_bin << 1) + SUM_W'(r_p1_cur[4*i +: 4]);
    end
  end

  // Capture the offered range and step the candidate through it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lo   <= '0;
      r_hi   <= '0;
      r_last <= 1'b0;
      r_mode <= 1'b0;
      r_cur  <= '0;
    end else begin
      if (w_accept) begin
        r_lo   <= rng_if.range_lo;
        r_hi   <= rng_if.range_hi;
        r_last <= rng_if.range_last;
        r_mode <= rng_if.mode;
      end
      if ((r_state == ST_CHECK) && !w_malformed) begin
        r_cur <= r_lo;
      end else if (r_state == ST_SCAN) begin
        r_cur <= w_cur_inc;
      end
    end
  end

  // Stage 1: register the candidate with its flag. The flag is only live while scanning.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p1_flag <= 1'b0;
      r_p1_cur  <= '0;
    end else begin
      r_p1_flag <= (r_state == ST_SCAN) && w_flag;
      r_p1_cur  <= r_cur;
    end
  end

  // Stage 2: accumulate flagged IDs (wrapping). A new batch clears the totals and the sticky bad flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum <= '0;
      r_cnt <= '0;
      r_bad <= 1'b0;
    end else if (w_new_batch) begin
      r_sum <= '0;
      r_cnt <= '0;
      r_bad <= 1'b0;
    end else begin
      if (r_p1_flag) begin
        r_sum <= r_sum + w_p1_bin;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if ((r_state == ST_CHECK) && w_malformed) begin
        r_bad <= 1'b1;
      end
    end
  end

  assign result    = r_sum;
  assign id_count  = r_cnt;
  assign bad_range = r_bad;

endmodule

// File: tb/tb_repeat_id_scanner.sv
// Testbench for repeat_id_scanner. It runs directed batches with known totals
// and latencies, then runs random batches that are scored against a decimal
// arithmetic model of the repeated-pattern rules.
module tb_repeat_id_scanner;

  localparam int DIGITS = 10;
  localparam int SUM_W  = 64;
  localparam int CNT_W  = 32;
  localparam int BW     = 4 * DIGITS;
  localparam int BUDGET = 5000;

  logic              clk = 1'b0;
  logic              rst;
  logic [SUM_W-1:0]  result;
  logic [CNT_W-1:0]  idCount;
  logic              resultValid;
  logic              badRange;

  int compared   = 0;
  int mismatched = 0;

  longint unsigned expSum;
  longint unsigned expCnt;
  bit              expBad;

  repeat_id_scanner_if #(.DIGITS(DIGITS)) rngIf ();

  repeat_id_scanner #(
    .DIGITS (DIGITS),
    .SUM_W  (SUM_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rng_if       (rngIf),
    .result       (result),
    .id_count     (idCount),
    .result_valid (resultValid),
    .bad_range    (badRange)
  );

  // Free-running 10-time-unit clock
  always #5 clk = ~clk;

  function automatic longint unsigned pow10(input int n);
    longint unsigned r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic int decLen(input longint unsigned v);
    int n = 1;
    longint unsigned t = v / 10;
    while (t != 0) begin
      n++;
      t = t / 10;
    end
    return n;
  endfunction

  // Reference rule: the ID is some block of p digits written k times.
  function automatic bit isInvalid(input longint unsigned v, input bit md);
    int len;
    longint unsigned pw, pat, rep;
    len = decLen(v);
    if (len == 1) return 1'b0;
    if (!md) begin
      if ((len % 2) != 0) return 1'b0;
      pw = pow10(len / 2);
      return (v / pw) == (v % pw);
    end
    for (int p = 1; p < len; p++) begin
      if ((len % p) == 0) begin
        pw  = pow10(p);
        pat = v % pw;
        rep = 0;
        for (int k = 0; k < len / p; k++) rep = rep * pw + pat;
        if (rep == v) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic logic [BW-1:0] toBcd(input longint unsigned v);
    logic [BW-1:0] b = '0;
    longint unsigned t = v;
    for (int i = 0; i < DIGITS; i++) begin
      b[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return b;
  endfunction

  task automatic modelRange(input longint unsigned lo, input longint unsigned hi, input bit md);
    if (lo > hi) begin
      expBad = 1'b1;
    end else begin
      for (longint unsigned v = lo; v <= hi; v++) begin
        if (isInvalid(v, md)) begin
          expSum = expSum + v;
          expCnt = expCnt + 1;
        end
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Called at a negedge. The task offers a range and waits (bounded) for the
  // accept. It returns at the negedge after the accept edge, in cycle T+1.
  // 'waited' counts the cycles spent with ready low.
  task automatic applyStimulus(input logic [BW-1:0] lo, input logic [BW-1:0] hi,
                               input bit last, input bit md, input bit hold, output int waited);
    rngIf.range_lo    = lo;
    rngIf.range_hi    = hi;
    rngIf.range_last  = last;
    rngIf.mode        = md;
    rngIf.range_valid = 1'b1;
    waited = 0;
    while ((rngIf.range_ready !== 1'b1) && (waited < BUDGET)) begin
      @(negedge clk);
      waited++;
    end
    compared++;
    assert (waited < BUDGET) else begin
      mismatched++;
      $error("[TB] FAIL accept_timeout: observed %0d cycles expected below %0d", waited, BUDGET);
    end
    if (waited < BUDGET) begin
      @(posedge clk);
      @(negedge clk);
    end
    if (!hold) rngIf.range_valid = 1'b0;
  endtask

  // Called in cycle T+1. The task returns k, the first cycle T+k with result_valid high.
  task automatic waitResult(output int lat);
    lat = 1;
    while ((resultValid !== 1'b1) && (lat < BUDGET)) begin
      @(negedge clk);
      lat++;
    end
    compared++;
    assert (lat < BUDGET) else begin
      mismatched++;
      $error("[TB] FAIL result_timeout: observed %0d cycles expected below %0d", lat, BUDGET);
    end
  endtask

  initial begin
    int w, lat, nR, kind;
    longint unsigned lo, hi, pat, base;
    bit md, last;

    rst = 1'b0;
    rngIf.range_valid = 1'b0;
    rngIf.range_lo    = '0;
    rngIf.range_hi    = '0;
    rngIf.range_last  = 1'b0;
    rngIf.mode        = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_ready", 64'(rngIf.range_ready), 64'd0);
    checkOutput("rst_result", result, 64'd0);
    checkOutput("rst_count", 64'(idCount), 64'd0);
    checkOutput("rst_valid", 64'(resultValid), 64'd0);
    checkOutput("rst_bad", 64'(badRange), 64'd0);
    rst = 1'b0;
    #1 checkOutput("rst_release_ready", 64'(rngIf.range_ready), 64'd1);

    // Mode 0, 11-22, single last range
    applyStimulus(toBcd(11), toBcd(22), 1'b1, 1'b0, 1'b0, w);
    waitResult(lat);
    checkOutput("t1_latency", 64'(lat), 64'd15);
    checkOutput("t1_result", result, 64'd33);
    checkOutput("t1_count", 64'(idCount), 64'd2);
    checkOutput("t1_bad", 64'(badRange), 64'd0);
    repeat (3) @(negedge clk);
    checkOutput("t1_held_valid", 64'(resultValid), 64'd1);
    checkOutput("t1_held_result", result, 64'd33);

    // Mode 1 then mode 0 on 95-115
    applyStimulus(toBcd(95), toBcd(115), 1'b1, 1'b1, 1'b0, w);
    checkOutput("t2_valid_falls", 64'(resultValid), 64'd0);
    checkOutput("t2_result_cleared", result, 64'd0);
    checkOutput("t2_count_cleared", 64'(idCount), 64'd0);
    waitResult(lat);
    checkOutput("t2_latency", 64'(lat), 64'd24);
    checkOutput("t2_m1_result", result, 64'd210);
    checkOutput("t2_m1_count", 64'(idCount), 64'd2);
    applyStimulus(toBcd(95), toBcd(115), 1'b1, 1'b0, 1'b0, w);
    waitResult(lat);
    checkOutput("t2_m0_result", result, 64'd99);
    checkOutput("t2_m0_count", 64'(idCount), 64'd1);

    // Length crossings and a 10-digit range in one batch, both modes
    applyStimulus(toBcd(998), toBcd(1012), 1'b0, 1'b1, 1'b0, w);
    applyStimulus(toBcd(64'd1188511880), toBcd(64'd1188511890), 1'b1, 1'b1, 1'b0, w);
    waitResult(lat);
    checkOutput("t3_m1_result", result, 64'd1188513894);
    checkOutput("t3_m1_count", 64'(idCount), 64'd3);
    applyStimulus(toBcd(998), toBcd(1012), 1'b0, 1'b0, 1'b0, w);
    applyStimulus(toBcd(64'd1188511880), toBcd(64'd1188511890), 1'b1, 1'b0, 1'b0, w);
    waitResult(lat);
    checkOutput("t3_m0_result", result, 64'd1188512895);
    checkOutput("t3_m0_count", 64'(idCount), 64'd2);

    // Back-to-back ranges with range_valid held high
    applyStimulus(toBcd(11), toBcd(22), 1'b0, 1'b0, 1'b1, w);
    applyStimulus(toBcd(95), toBcd(115), 1'b1, 1'b0, 1'b0, w);
    checkOutput("t4_accept_gap", 64'(w), 64'd13);
    waitResult(lat);
    checkOutput("t4_latency", 64'(lat), 64'd24);
    checkOutput("t4_result", result, 64'd132);
    checkOutput("t4_count", 64'(idCount), 64'd3);

    // Malformed ranges are skipped and raise bad_range
    applyStimulus(toBcd(22), toBcd(11), 1'b0, 1'b0, 1'b0, w);
    @(negedge clk);
    checkOutput("t5_bad_sticky", 64'(badRange), 64'd1);
    applyStimulus(40'h0A, 40'h15, 1'b0, 1'b0, 1'b0, w);
    checkOutput("t5_bad_gap", 64'(w), 64'd0);
    applyStimulus(toBcd(11), toBcd(22), 1'b1, 1'b0, 1'b0, w);
    waitResult(lat);
    checkOutput("t5_bad", 64'(badRange), 64'd1);
    checkOutput("t5_result", result, 64'd33);
    checkOutput("t5_count", 64'(idCount), 64'd2);

    // Reset in the middle of a long scan
    applyStimulus(toBcd(1), toBcd(999999), 1'b1, 1'b0, 1'b0, w);
    repeat (200) @(negedge clk);
    checkOutput("t6_partial_count", 64'(idCount), 64'd9);
    checkOutput("t6_partial_sum", result, 64'd495);
    #1 rst = 1'b1;
    #1;
    checkOutput("t6_rst_result", result, 64'd0);
    checkOutput("t6_rst_count", 64'(idCount), 64'd0);
    checkOutput("t6_rst_valid", 64'(resultValid), 64'd0);
    checkOutput("t6_rst_ready", 64'(rngIf.range_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(toBcd(11), toBcd(22), 1'b1, 1'b0, 1'b0, w);
    waitResult(lat);
    checkOutput("t6_latency", 64'(lat), 64'd15);
    checkOutput("t6_result", result, 64'd33);
    checkOutput("t6_bad", 64'(badRange), 64'd0);

    // Random batches scored against the decimal model
    for (int b = 0; b < 6; b++) begin
      expSum = 0;
      expCnt = 0;
      expBad = 1'b0;
      nR = $urandom_range(1, 3);
      for (int r = 0; r < nR; r++) begin
        kind = $urandom_range(0, 3);
        case (kind)
          0: lo = longint'($urandom_range(0, 2000));
          1: lo = longint'($urandom_range(100000, 999000));
          2: begin
            pat  = longint'($urandom_range(1000, 9999));
            base = pat * 10001;
            lo   = base - longint'($urandom_range(0, 60));
          end
          default: begin
            pat  = longint'($urandom_range(10, 99));
            base = pat * 10101;
            lo   = base - longint'($urandom_range(0, 60));
          end
        endcase
        hi = lo + longint'($urandom_range(0, 150));
        if ($urandom_range(0, 7) == 0) begin
          base = lo;
          lo   = hi + 1;
          hi   = base;
        end
        md   = 1'($urandom_range(0, 1));
        last = (r == nR - 1);
        modelRange(lo, hi, md);
        applyStimulus(toBcd(lo), toBcd(hi), last, md, 1'b0, w);
      end
      waitResult(lat);
      checkOutput($sformatf("rnd%0d_result", b), result, expSum);
      checkOutput($sformatf("rnd%0d_count", b), 64'(idCount), expCnt);
      checkOutput($sformatf("rnd%0d_bad", b), 64'(badRange), 64'(expBad));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
